// File: rtl/mx_pkg.sv
// Shared constants, state encoding and width helper for the mxn selector.
package mx_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Ceil-log2 with a floor of 1 so one-value counters still get a bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mxn_w.sv
// Combinational WIDTH-bit CH:1 multiplexer over a flattened channel bus.
module mxn_w
    import mx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CH    = 8,
    localparam int SELW = clog2(CH)
) (
    output logic [WIDTH-1:0]    y,
    input  logic [CH*WIDTH-1:0] d_in,
    input  logic [SELW-1:0]     sel
);

    always_comb begin
        y = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SELW'(i)) y = d_in[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mxn_scan.sv
// Registered N-channel selector with manual select and dwell-timed auto-scan.
module mxn_scan
    import mx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CH    = 8,
    parameter int DWELL = 4,
    localparam int SELW = clog2(CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH*WIDTH-1:0] d_in,
    input  logic                en,
    input  logic                mode,
    input  logic [SELW-1:0]     sel_in,
    input  logic                sel_ld,
    output logic [WIDTH-1:0]    y,
    output logic [SELW-1:0]     y_sel,
    output logic                y_valid,
    output logic                wrap,
    output logic                sel_err
);

    localparam int              DCW  = clog2(DWELL);
    localparam logic [DCW-1:0]  DMAX = DCW'(DWELL - 1);
    localparam logic [SELW-1:0] SMAX = SELW'(CH - 1);
    localparam logic [SELW:0]   CHV  = (SELW + 1)'(CH);

    state_t            r_state;
    state_t            w_nxt;
    logic [SELW-1:0]   r_sel;
    logic [SELW-1:0]   w_sel;
    logic [DCW-1:0]    r_dcnt;
    logic [DCW-1:0]    w_dcnt;
    logic [DCW-1:0]    w_base;
    logic              w_ok;
    logic              w_wrap;
    logic              w_err;
    logic [WIDTH-1:0]  w_mux;

    mxn_w #(
        .WIDTH (WIDTH),
        .CH    (CH)
    ) u_mux (
        .y    (w_mux),
        .d_in (d_in),
        .sel  (r_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = IDLE;
        unique case (1'b1)
            !en:                         w_nxt = IDLE;
            (en && mode == MODE_MANUAL): w_nxt = MANUAL;
            (en && mode == MODE_SCAN):   w_nxt = SCAN;
        endcase
    end

    // Leaving MANUAL restarts the dwell; IDLE keeps it so a paused scan resumes.
    always_comb begin
        w_ok   = {1'b0, sel_in} < CHV;
        w_base = (r_state == MANUAL) ? '0 : r_dcnt;
        w_sel  = r_sel;
        w_dcnt = r_dcnt;
        w_wrap = 1'b0;
        w_err  = 1'b0;
        if (sel_ld && w_ok) begin
            w_sel  = sel_in;
            w_dcnt = '0;
        end else if (sel_ld) begin
            w_err = 1'b1;
        end else if (w_nxt == SCAN) begin
            if (w_base == DMAX) begin
                w_dcnt = '0;
                if (r_sel == SMAX) begin
                    w_sel  = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_sel = r_sel + 1'b1;
                end
            end else begin
                w_dcnt = w_base + 1'b1;
            end
        end else if (w_nxt == MANUAL) begin
            w_dcnt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel   <= '0;
            r_dcnt  <= '0;
            y       <= '0;
            y_sel   <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            r_sel   <= w_sel;
            r_dcnt  <= w_dcnt;
            y_valid <= en;
            wrap    <= w_wrap;
            sel_err <= w_err;
            if (en) begin
                y     <= w_mux;
                y_sel <= r_sel;
            end
        end
    end

endmodule

// File: tb/tb_mxn_scan.sv
// Bench for mxn_scan: two instances (CH=8/DWELL=2 and CH=5/DWELL=3) vs a tick model.
module tb_mxn_scan;

    localparam int W   = 4;
    localparam int CHA = 8;
    localparam int DA  = 2;
    localparam int CHB = 5;
    localparam int DB  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [CHA*W-1:0] da_in;
    logic [CHB*W-1:0] db_in;
    logic            a_en, a_mode, a_ld;
    logic [2:0]      a_sin;
    logic            b_en, b_mode, b_ld;
    logic [2:0]      b_sin;
    logic [W-1:0]    a_y, b_y;
    logic [2:0]      a_ysel, b_ysel;
    logic            a_v, a_w, a_e, b_v, b_w, b_e;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_sel [2];
    int         m_cnt [2];
    int         m_ys  [2];
    logic [W-1:0] m_y [2];
    logic       m_v   [2];
    logic       m_w   [2];
    logic       m_e   [2];

    always #5 clk = ~clk;

    mxn_scan #(.WIDTH(W), .CH(CHA), .DWELL(DA)) u_a (
        .clk(clk), .reset(reset), .d_in(da_in), .en(a_en), .mode(a_mode),
        .sel_in(a_sin), .sel_ld(a_ld), .y(a_y), .y_sel(a_ysel),
        .y_valid(a_v), .wrap(a_w), .sel_err(a_e)
    );

    mxn_scan #(.WIDTH(W), .CH(CHB), .DWELL(DB)) u_b (
        .clk(clk), .reset(reset), .d_in(db_in), .en(b_en), .mode(b_mode),
        .sel_in(b_sin), .sel_ld(b_ld), .y(b_y), .y_sel(b_ysel),
        .y_valid(b_v), .wrap(b_w), .sel_err(b_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_cnt[k] = 0; m_ys[k] = 0; m_y[k] = '0;
            m_v[k] = 1'b0; m_w[k] = 1'b0; m_e[k] = 1'b0;
        end
    endtask

    // One clock edge of the behaviour: m_cnt counts ticks spent on a channel.
    task automatic mstep(input int k, input int ch, input int dw, input logic e,
                         input logic md, input logic l, input int s,
                         input logic [39:0] bus);
        m_w[k] = 1'b0;
        m_e[k] = 1'b0;
        m_v[k] = e;
        if (e) begin
            m_y[k]  = bus[m_sel[k]*W +: W];
            m_ys[k] = m_sel[k];
        end
        if (l && s < ch) begin
            m_sel[k] = s;
            m_cnt[k] = 0;
        end else if (l) begin
            m_e[k] = 1'b1;
        end else if (e && md) begin
            m_cnt[k]++;
            if (m_cnt[k] == dw) begin
                m_cnt[k] = 0;
                m_w[k]   = (m_sel[k] == ch - 1);
                m_sel[k] = (m_sel[k] + 1) % ch;
            end
        end else if (e) begin
            m_cnt[k] = 0;
        end
    endtask

    task automatic cyc();
        mstep(0, CHA, DA, a_en, a_mode, a_ld, int'(a_sin), 40'(da_in));
        mstep(1, CHB, DB, b_en, b_mode, b_ld, int'(b_sin), 40'(db_in));
        @(posedge clk);
        #1;
        chk("a_y", 32'(a_y), 32'(m_y[0]));
        chk("a_ysel", 32'(a_ysel), 32'(m_ys[0]));
        chk("a_valid", 32'(a_v), 32'(m_v[0]));
        chk("a_wrap", 32'(a_w), 32'(m_w[0]));
        chk("a_err", 32'(a_e), 32'(m_e[0]));
        chk("b_y", 32'(b_y), 32'(m_y[1]));
        chk("b_ysel", 32'(b_ysel), 32'(m_ys[1]));
        chk("b_valid", 32'(b_v), 32'(m_v[1]));
        chk("b_wrap", 32'(b_w), 32'(m_w[1]));
        chk("b_err", 32'(b_e), 32'(m_e[1]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ay"}, 32'(a_y), 0);
        chk({tag, "_aysel"}, 32'(a_ysel), 0);
        chk({tag, "_av"}, 32'(a_v), 0);
        chk({tag, "_aw"}, 32'(a_w), 0);
        chk({tag, "_ae"}, 32'(a_e), 0);
        chk({tag, "_by"}, 32'(b_y), 0);
        chk({tag, "_bv"}, 32'(b_v), 0);
    endtask

    // Called at posedge+1: reset pulses and is released before the next edge.
    task automatic areset();
        #2;
        reset = 1'b1;
        #1;
        chk_zero("areset");
        reset = 1'b0;
        mreset();
    endtask

    int wraps;
    int found;

    initial begin
        reset = 1'b1;
        da_in = '0; db_in = '0;
        a_en = 1'b0; a_mode = 1'b0; a_ld = 1'b0; a_sin = '0;
        b_en = 1'b0; b_mode = 1'b0; b_ld = 1'b0; b_sin = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Manual load of channel 5 where channel i carries i+3
        for (int i = 0; i < CHA; i++) da_in[i*W +: W] = W'(i + 3);
        a_en = 1'b1; a_mode = 1'b0; a_ld = 1'b1; a_sin = 3'd5;
        cyc();
        a_ld = 1'b0;
        cyc();
        chk("man_y", 32'(a_y), 8);
        chk("man_ysel", 32'(a_ysel), 5);
        chk("man_valid", 32'(a_v), 1);

        // Scan from reset
        areset();
        a_mode = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 32; i++) begin
            cyc();
            chk("scan_ysel", 32'(a_ysel), 32'(((i - 1) / 2) % 8));
            chk("scan_y", 32'(a_y), 32'(((i - 1) / 2) % 8 + 3));
            chk("scan_wrap", 32'(a_w), 32'(i % 16 == 0));
            if (a_w) wraps++;
        end
        chk("scan_wraps", 32'(wraps), 2);

        // Load on the edge that would wrap 7->0
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (m_sel[0] == 7 && m_cnt[0] == DA - 1) found = 1;
            else cyc();
        end
        chk("coll_reach", 32'(found), 1);
        a_ld = 1'b1; a_sin = 3'd2;
        cyc();
        chk("coll_wrap", 32'(a_w), 0);
        a_ld = 1'b0;
        cyc();
        chk("coll_ysel0", 32'(a_ysel), 2);
        chk("coll_nowrap", 32'(a_w), 0);
        cyc();
        chk("coll_ysel1", 32'(a_ysel), 2);
        cyc();
        chk("coll_ysel2", 32'(a_ysel), 3);

        // Freeze mid-dwell on channel 3
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (m_sel[0] == 3 && m_cnt[0] == 1) found = 1;
            else cyc();
        end
        chk("frz_reach", 32'(found), 1);
        a_en = 1'b0;
        repeat (3) begin
            cyc();
            chk("frz_valid", 32'(a_v), 0);
            chk("frz_y", 32'(a_y), 6);
        end
        a_en = 1'b1;
        cyc();
        chk("frz_resume_ysel", 32'(a_ysel), 3);
        chk("frz_resume_valid", 32'(a_v), 1);
        cyc();
        chk("frz_next_ysel", 32'(a_ysel), 4);

        // Out-of-range load on the 5-channel instance
        db_in = 20'($urandom);
        b_en = 1'b1; b_mode = 1'b0; b_ld = 1'b1; b_sin = 3'd2;
        cyc();
        b_ld = 1'b0;
        cyc();
        b_ld = 1'b1; b_sin = 3'd6;
        cyc();
        chk("oor_err", 32'(b_e), 1);
        chk("oor_ysel", 32'(b_ysel), 2);
        b_ld = 1'b0;
        cyc();
        chk("oor_err_clr", 32'(b_e), 0);
        chk("oor_ysel_hold", 32'(b_ysel), 2);

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            a_en   = ($urandom_range(0, 9) != 0);
            a_mode = ($urandom_range(0, 3) != 0);
            a_ld   = ($urandom_range(0, 15) == 0);
            a_sin  = 3'($urandom);
            da_in  = 32'($urandom);
            b_en   = ($urandom_range(0, 9) != 0);
            b_mode = ($urandom_range(0, 3) != 0);
            b_ld   = ($urandom_range(0, 11) == 0);
            b_sin  = 3'($urandom);
            db_in  = 20'($urandom);
            if ($urandom_range(0, 99) == 0) areset();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
